i2c_txn_arbiter: RTL and testbench
==================================

// Module: i2c_txn_arbiter
// PURPOSE
//  Shares one i2c_ctrl master among NUM_REQ requesters using round-robin arbitration.
//  Latches the winner's command and issues a 1-cycle launch to the master.
//  Tracks master busy and byte_done, routes per-byte strobes to the granted requester,
//  and reports completion/error. Sits between client blocks and i2c_ctrl.
// PARAMETERS
//  NUM_REQ   2      number of requesters (2..8)
//  TIMEOUT   1023   max cycles waiting for busy, or between byte strobes, before abort
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          async active-low reset
//  req          in   NUM_REQ    per-requester transaction request (level)
//  req_wr       in   NUM_REQ    1=write, 0=read
//  req_addr     in   7*NUM_REQ  7-bit slave address, requester i at [7i+:7]
//  req_nbytes   in   8*NUM_REQ  byte count, requester i at [8i+:8]
//  req_wdata    in   8*NUM_REQ  current write byte, requester i at [8i+:8]
//  gnt          out  NUM_REQ    one-hot grant, held for whole transaction
//  byte_strb    out  NUM_REQ    1-cycle pulse to granted requester per completed byte
//  done         out  NUM_REQ    1-cycle completion pulse to granted requester
//  err          out  1          valid with done: 1 = timeout/short transfer/zero length
//  m_start      out  1          1-cycle launch to master (drives slave_ready)
//  m_wr         out  1          to master wr_ctrl
//  m_addr       out  7          to master i2c_slave_addr
//  m_nbytes     out  8          to master data_bytes
//  m_wdata      out  8          to master w_data
//  m_busy       in   1          master i2c_busy
//  m_byte_done  in   1          master byte_done (level; edge-detected here)
//  arb_busy     out  1          high from ARB through DONE/ERR
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; last_grant = NUM_REQ-1, so req[0] has first priority.
//  FSM: IDLE -> ARB -> LAUNCH -> WAIT_BUSY -> RUN -> DONE -> IDLE; abort paths go to ERR -> IDLE.
//  IDLE: when |req, go to ARB next cycle.
//  ARB (1 cycle): search from last_grant+1, wrapping modulo NUM_REQ.
//   - First asserted req wins; set gnt and latch wr/addr/nbytes into m_* registers.
//   - If the latched nbytes == 0, go to ERR without launching.
//  LAUNCH: m_start=1 for exactly 1 cycle, then WAIT_BUSY.
//  WAIT_BUSY: go to RUN when m_busy=1. If TIMEOUT cycles elapse first, go to ERR.
//  RUN:
//   - Each rising edge of m_byte_done (registered edge detect, +1 cycle latency):
//     byte_strb[g]=1 for 1 cycle, byte_cnt++, timeout counter cleared.
//   - m_busy falling (1->0): go to DONE.
//   - TIMEOUT cycles with no strobe and busy still high: go to ERR.
//  DONE: done[g]=1 for 1 cycle; err = (byte_cnt != latched nbytes).
//   - Update last_grant=g, clear gnt, return to IDLE.
//  ERR: done[g]=1, err=1 for 1 cycle; update last_grant, clear gnt, return to IDLE.
//  m_wdata: registered copy of req_wdata[g] every cycle while gnt!=0, otherwise held.
//  m_wr/m_addr/m_nbytes: stable from ARB until the next ARB.
//  Requester rules:
//   - A requester must hold req high until its done pulse.
//   - req dropping mid-transaction is ignored; the transaction runs to completion.
//   - A requester may re-request in the cycle after done; round-robin still applies.
//  Simultaneous requests are resolved only in ARB; new reqs during a transaction wait.
//  byte_cnt is 8 bits and saturates at 255. Timeout counter is clog2(TIMEOUT+1) bits.
//  Async reset mid-transaction: immediate return to reset values; no done pulse is issued.
// TESTING
//  1 Single write: req[0], wr=1, addr=0x50, nbytes=2; model busy 40 cyc, 2 byte_done
//    -> one m_start; byte_strb[0] x2; done[0] with err=0.
//  2 Contention: req=2'b11 held, last_grant=1 after reset
//    -> grants in order 0,1,0,1; gnt never has 2 bits set.
//  3 No response: m_busy stuck at 0 -> ERR after TIMEOUT cycles; done[g]=1, err=1.
//  4 Short read: nbytes=3, master ends busy after 1 byte_done -> done with err=1.
//  5 Zero length: nbytes=0 -> no m_start; done+err 2 cycles after req.
//  6 Reset mid-RUN: rst_n low 3 cycles -> all outputs 0; req[0] gets the next grant.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one i2c_ctrl master among NUM_REQ requesters.
// The winner's command is latched and launched with a one-cycle start.
// Master activity is tracked: busy handshake, per-byte strobes routed to the
// granted requester, timeout supervision, and a done/err completion pulse.
module i2c_txn_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_wr,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_nbytes,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     byte_strb,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    output logic                   m_start,
    output logic                   m_wr,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_nbytes,
    output logic [7:0]             m_wdata,
    input  logic                   m_busy,
    input  logic                   m_byte_done,
    output logic                   arb_busy
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [IW-1:0]     r_last;
    logic [IW-1:0]     r_gidx;
    logic [NUM_REQ-1:0] r_gnt;
    logic              r_m_wr;
    logic [6:0]        r_m_addr;
    logic [7:0]        r_m_nbytes;
    logic [7:0]        r_m_wdata;
    logic [7:0]        r_byte_cnt;
    logic [TW-1:0]     r_tmo;
    logic              r_bd_q;
    logic              r_bd_pulse;
    logic              r_busy_q;
    logic              r_busy_fall;

    logic              w_win_valid;
    logic [IW-1:0]     w_win_idx;
    logic              w_win_wr;
    logic [6:0]        w_win_addr;
    logic [7:0]        w_win_nb;
    logic [7:0]        w_g_wdata;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!w_win_valid && req[IW'((32'(r_last) + k) % NUM_REQ)]) begin
                w_win_valid = 1'b1;
                w_win_idx   = IW'((32'(r_last) + k) % NUM_REQ);
            end
        end
    end

    // Select the winner's command fields and the granted requester's write byte
    always_comb begin
        w_win_wr   = 1'b0;
        w_win_addr = '0;
        w_win_nb   = '0;
        w_g_wdata  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == IW'(i)) begin
                w_win_wr   = req_wr[i];
                w_win_addr = req_addr[7*i +: 7];
                w_win_nb   = req_nbytes[8*i +: 8];
            end
            if (r_gidx == IW'(i)) begin
                w_g_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state output pulses
    always_comb begin
        w_next    = r_state;
        m_start   = 1'b0;
        done      = '0;
        err       = 1'b0;
        byte_strb = '0;
        arb_busy  = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_next = S_ARB;
                end
            end
            S_ARB: begin
                if (!w_win_valid) begin
                    w_next = S_IDLE;
                end else if (w_win_nb == '0) begin
                    w_next = S_ERR;
                end else begin
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                m_start = 1'b1;
                w_next  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (m_busy) begin
                    w_next = S_RUN;
                end else if (r_tmo == TMO_LAST) begin
                    w_next = S_ERR;
                end
            end
            S_RUN: begin
                if (r_bd_pulse) begin
                    byte_strb = r_gnt;
                end
                // busy fall and byte pulse share the same one-cycle latency,
                // so a final byte coinciding with the fall is still counted
                if (r_busy_fall) begin
                    w_next = S_DONE;
                end else if (!r_bd_pulse && m_busy && r_tmo == TMO_LAST) begin
                    w_next = S_ERR;
                end
            end
            S_DONE: begin
                done   = r_gnt;
                err    = (r_byte_cnt != r_m_nbytes);
                w_next = S_IDLE;
            end
            S_ERR: begin
                done   = r_gnt;
                err    = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Edge detectors for master byte_done and busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bd_q      <= 1'b0;
            r_bd_pulse  <= 1'b0;
            r_busy_q    <= 1'b0;
            r_busy_fall <= 1'b0;
        end else begin
            r_bd_q      <= m_byte_done;
            r_bd_pulse  <= m_byte_done & ~r_bd_q;
            r_busy_q    <= m_busy;
            r_busy_fall <= r_busy_q & ~m_busy;
        end
    end

    // Grant, command latch, byte counter, timeout counter and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= IW'(NUM_REQ - 1);
            r_gidx     <= '0;
            r_gnt      <= '0;
            r_m_wr     <= 1'b0;
            r_m_addr   <= '0;
            r_m_nbytes <= '0;
            r_m_wdata  <= '0;
            r_byte_cnt <= '0;
            r_tmo      <= '0;
        end else begin
            if (r_gnt != '0) begin
                r_m_wdata <= w_g_wdata;
            end
            case (r_state)
                S_ARB: begin
                    if (w_win_valid) begin
                        r_gidx     <= w_win_idx;
                        r_gnt      <= NUM_REQ'(1) << w_win_idx;
                        r_m_wr     <= w_win_wr;
                        r_m_addr   <= w_win_addr;
                        r_m_nbytes <= w_win_nb;
                        r_byte_cnt <= '0;
                    end
                end
                S_LAUNCH: begin
                    r_tmo <= '0;
                end
                S_WAIT_BUSY: begin
                    if (m_busy) begin
                        r_tmo <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_bd_pulse) begin
                        r_tmo <= '0;
                        if (r_byte_cnt != 8'hFF) begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    r_last <= r_gidx;
                    r_gnt  <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign m_wr     = r_m_wr;
    assign m_addr   = r_m_addr;
    assign m_nbytes = r_m_nbytes;
    assign m_wdata  = r_m_wdata;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: vector table of transactions,
// behavioural i2c master model, scoreboard of expected completions.
`timescale 1ns/1ps
module tb_i2c_txn_arbiter;

    localparam int NR  = 2;
    localparam int TMO = 30;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR-1:0]    req_wr;
    logic [7*NR-1:0]  req_addr;
    logic [8*NR-1:0]  req_nbytes;
    logic [8*NR-1:0]  req_wdata;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    byte_strb;
    logic [NR-1:0]    done;
    logic             err;
    logic             m_start;
    logic             m_wr;
    logic [6:0]       m_addr;
    logic [7:0]       m_nbytes;
    logic [7:0]       m_wdata;
    logic             m_busy;
    logic             m_byte_done;
    logic             arb_busy;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_nbytes(req_nbytes), .req_wdata(req_wdata),
        .gnt(gnt), .byte_strb(byte_strb), .done(done), .err(err),
        .m_start(m_start), .m_wr(m_wr), .m_addr(m_addr), .m_nbytes(m_nbytes),
        .m_wdata(m_wdata), .m_busy(m_busy), .m_byte_done(m_byte_done),
        .arb_busy(arb_busy)
    );

    typedef struct {
        int         idx;
        logic       wr;
        logic [6:0] addr;
        logic [7:0] nb;
        int         mbytes;
        bit         respond;
        bit         exp_err;
        int         exp_strb;
        int         exp_starts;
        int         exp_lat;
    } vec_t;

    typedef struct {
        int         idx;
        logic       wr;
        logic [6:0] addr;
        logic [7:0] nb;
        bit         err;
        int         strb;
        int         starts;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mdl_bytes = 0;
    bit   mdl_respond = 1'b0;
    bit   mdl_active = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic logic [7:0] exp_wd(input logic [NR-1:0] g);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) if (g[i]) r = req_wdata[8*i +: 8];
        return r;
    endfunction

    // ---------------- master model ----------------
    task automatic mwait(input int n, inout bit ab);
        for (int k = 0; k < n && !ab; k++) begin
            @(posedge clk); #1;
            if (!rst_n) ab = 1'b1;
        end
    endtask

    task automatic master_run(input int nb);
        bit ab;
        ab = 1'b0;
        mwait(3, ab);
        if (!ab) m_busy = 1'b1;
        for (int b = 0; b < nb && !ab; b++) begin
            mwait(6, ab);
            if (!ab) m_byte_done = 1'b1;
            mwait(3, ab);
            m_byte_done = 1'b0;
        end
        mwait(20, ab);
        m_busy      = 1'b0;
        m_byte_done = 1'b0;
    endtask

    initial begin : master
        m_busy      = 1'b0;
        m_byte_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && m_start && mdl_respond) begin
                mdl_active = 1'b1;
                master_run(mdl_bytes);
                mdl_active = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : mon
        int            strb_cnt;
        int            start_cnt;
        int            lat;
        logic [NR-1:0] prev_gnt;
        exp_t          e;
        strb_cnt  = 0;
        start_cnt = 0;
        lat       = -1;
        prev_gnt  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                strb_cnt  = 0;
                start_cnt = 0;
                lat       = -1;
                prev_gnt  = '0;
            end else begin
                if ($countones(gnt) > 1) check("gnt_onehot", gnt, 0);
                if (lat >= 0) lat++;
                if (m_start) begin
                    start_cnt++;
                    lat = 0;
                end
                strb_cnt += $countones(byte_strb);
                if (prev_gnt != '0 && gnt == prev_gnt) check("m_wdata", m_wdata, exp_wd(gnt));
                if (done != '0) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_done", done, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("done_onehot", done, 64'd1 << e.idx);
                        check("err", err, e.err);
                        check("strobe_count", strb_cnt, e.strb);
                        check("m_start_count", start_cnt, e.starts);
                        check("m_wr", m_wr, e.wr);
                        check("m_addr", m_addr, e.addr);
                        check("m_nbytes", m_nbytes, e.nb);
                        if (e.lat >= 0) check("timeout_latency", lat, e.lat);
                    end
                    strb_cnt  = 0;
                    start_cnt = 0;
                    lat       = -1;
                end else if (err) begin
                    check("err_without_done", err, 0);
                end
                prev_gnt = gnt;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_cfg(input int i, input logic wr, input logic [6:0] a,
                           input logic [7:0] nb, input logic [7:0] wd);
        req_wr[i]            = wr;
        req_addr[7*i +: 7]   = a;
        req_nbytes[8*i +: 8] = nb;
        req_wdata[8*i +: 8]  = wd;
    endtask

    task automatic push_exp(input int i, input bit e, input int strb,
                            input int starts, input int lat);
        exp_t x;
        x.idx    = i;
        x.wr     = req_wr[i];
        x.addr   = req_addr[7*i +: 7];
        x.nb     = req_nbytes[8*i +: 8];
        x.err    = e;
        x.strb   = strb;
        x.starts = starts;
        x.lat    = lat;
        sbq.push_back(x);
    endtask

    task automatic wait_any_done(output int which);
        which = -1;
        for (int c = 0; c < 400 && which < 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) if (done[i]) which = i;
        end
        if (which < 0) bound_fail("wait_done");
    endtask

    task automatic run_vec(input vec_t t, input int v);
        int w;
        mdl_bytes   = t.mbytes;
        mdl_respond = t.respond;
        set_cfg(t.idx, t.wr, t.addr, t.nb, 8'(8'h3C + v * 17));
        push_exp(t.idx, t.exp_err, t.exp_strb, t.exp_starts, t.exp_lat);
        req[t.idx] = 1'b1;
        wait_any_done(w);
        req[t.idx] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- main test ----------------
    initial begin : stim
        vec_t tbl[7];
        int   w;
        int   c;

        tbl[0] = '{0, 1'b1, 7'h50, 8'd2, 2, 1'b1, 1'b0, 2, 1, -1};      // single write
        tbl[1] = '{1, 1'b0, 7'h21, 8'd1, 1, 1'b1, 1'b0, 1, 1, -1};
        tbl[2] = '{0, 1'b0, 7'h33, 8'd3, 1, 1'b1, 1'b1, 1, 1, -1};      // short read
        tbl[3] = '{1, 1'b1, 7'h7F, 8'd0, 0, 1'b0, 1'b1, 0, 0, -1};      // zero length
        tbl[4] = '{0, 1'b1, 7'h11, 8'd4, 0, 1'b0, 1'b1, 0, 1, TMO + 1}; // no response
        tbl[5] = '{1, 1'b1, 7'h0A, 8'd5, 5, 1'b1, 1'b0, 5, 1, -1};
        tbl[6] = '{0, 1'b0, 7'h6C, 8'd2, 3, 1'b1, 1'b1, 3, 1, -1};      // extra byte

        rst_n      = 1'b0;
        req        = '0;
        req_wr     = '0;
        req_addr   = '0;
        req_nbytes = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {gnt, byte_strb, done, err, m_start, m_wr, m_addr,
                                m_nbytes, m_wdata, arb_busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_arb_busy", arb_busy, 0);

        // contention straight after reset: req[0] first, then alternate
        mdl_bytes   = 1;
        mdl_respond = 1'b1;
        set_cfg(0, 1'b1, 7'h40, 8'd1, 8'h5A);
        set_cfg(1, 1'b0, 7'h41, 8'd1, 8'hA5);
        push_exp(0, 1'b0, 1, 1, -1);
        push_exp(1, 1'b0, 1, 1, -1);
        push_exp(0, 1'b0, 1, 1, -1);
        push_exp(1, 1'b0, 1, 1, -1);
        req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_any_done(w);
            if (n == 2) req[0] = 1'b0;
            if (n == 3) req[1] = 1'b0;
        end
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) run_vec(tbl[v], v);

        // zero length: done+err exactly two cycles after req, no launch
        mdl_respond = 1'b0;
        set_cfg(1, 1'b0, 7'h12, 8'd0, 8'h77);
        push_exp(1, 1'b1, 0, 0, -1);
        req[1] = 1'b1;
        @(negedge clk);
        check("zl_arb_busy", arb_busy, 1);
        check("zl_no_early_done", done, 0);
        @(negedge clk);
        check("zl_done", done, 2'b10);
        check("zl_err", err, 1);
        check("zl_no_start", m_start, 0);
        req[1] = 1'b0;
        @(negedge clk);
        check("zl_back_idle", arb_busy, 0);
        repeat (2) @(negedge clk);

        // reset in the middle of RUN
        mdl_bytes   = 6;
        mdl_respond = 1'b1;
        set_cfg(1, 1'b1, 7'h55, 8'd1, 8'h99);
        set_cfg(0, 1'b1, 7'h44, 8'd6, 8'h66);
        req[0] = 1'b1;
        c = 0;
        while (byte_strb[0] !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) bound_fail("wait_first_strobe");
        rst_n = 1'b0;
        req   = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrun_reset_outputs", {gnt, byte_strb, done, err, m_start, m_wr,
                                           m_addr, m_nbytes, m_wdata, arb_busy}, 0);
        end
        c = 0;
        while (mdl_active && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) bound_fail("wait_master_abort");
        rst_n = 1'b1;
        @(negedge clk);
        mdl_bytes = 1;
        set_cfg(0, 1'b0, 7'h44, 8'd1, 8'h66);
        push_exp(0, 1'b0, 1, 1, -1);
        push_exp(1, 1'b0, 1, 1, -1);
        req = 2'b11;
        for (int n = 0; n < 2; n++) begin
            wait_any_done(w);
            req[w >= 0 ? w : 0] = 1'b0;
        end
        repeat (5) @(negedge clk);

        check("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
